// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared encodings for the fetch-side PC sequencer
package cpu_types_pkg;
    typedef enum logic [1:0] {
        PCSRC_JR  = 2'd0,
        PCSRC_J   = 2'd1,
        PCSRC_BR  = 2'd2,
        PCSRC_SEQ = 2'd3
    } pcsrc_t;
    typedef enum logic [1:0] {RUN, WAIT_D, REDIRECT, HALTED} seq_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: increment-on-enable counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] ONE = 1;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) count <= '0;
        else if (inc && ~&count) count <= count + ONE;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC load/select sequencing across fetch waits, data stalls, redirects and halt
module pc_sequencer
    import cpu_types_pkg::*;
#(
    parameter int         CNT_W  = 32,
    parameter logic [1:0] PC_SEQ = 2'd3
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             halt,
    input  logic             jr_req,
    input  logic             j_req,
    input  logic             br_req,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             imemREN,
    output logic             stall,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
);
    seq_state_t state, nxt;
    pcsrc_t     psrc, rsrc;
    logic       pend, hpend, latch, clr, hset, redir, dwait;
    assign redir = jr_req | j_req | br_req;
    assign rsrc  = jr_req ? PCSRC_JR : (j_req ? PCSRC_J : PCSRC_BR);
    assign dwait = dmem_req & ~dhit;
    always_comb begin
        pc_en   = 1'b0;
        pc_src  = PC_SEQ;
        imemREN = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        halted  = 1'b0;
        nxt     = state;
        latch   = 1'b0;
        clr     = 1'b0;
        hset    = 1'b0;
        if (nRST) begin
            case (state)
                RUN: begin
                    imemREN = ~dwait;
                    if (halt) begin
                        stall = dwait;
                        hset  = dwait;
                        nxt   = dwait ? WAIT_D : HALTED;
                    end else if (dwait) begin
                        stall = 1'b1;
                        latch = redir;
                        nxt   = WAIT_D;
                    end else if (redir && ihit) begin
                        pc_en  = 1'b1;
                        pc_src = rsrc;
                        flush  = 1'b1;
                    end else if (redir) begin
                        stall = 1'b1;
                        latch = 1'b1;
                        nxt   = REDIRECT;
                    end else begin
                        pc_en = ihit;
                    end
                end
                WAIT_D: begin
                    stall = 1'b1;
                    latch = redir & ~pend;
                    hset  = halt;
                    if (dhit) nxt = (halt | hpend) ? HALTED : ((pend | redir) ? REDIRECT : RUN);
                end
                REDIRECT: begin
                    imemREN = ~dwait;
                    stall   = 1'b1;
                    if (halt) begin
                        hset = dwait;
                        nxt  = dwait ? WAIT_D : HALTED;
                    end else if (dwait) begin
                        nxt = WAIT_D;
                    end else if (ihit) begin
                        pc_en  = 1'b1;
                        pc_src = psrc;
                        flush  = 1'b1;
                        clr    = 1'b1;
                        nxt    = RUN;
                    end
                end
                HALTED: halted = 1'b1;
            endcase
        end
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            pend  <= 1'b0;
            psrc  <= PCSRC_SEQ;
            hpend <= 1'b0;
        end else begin
            state <= nxt;
            if (latch) begin
                pend <= 1'b1;
                psrc <= rsrc;
            end else if (clr) begin
                pend <= 1'b0;
            end
            if (hset) hpend <= 1'b1;
        end
    end
    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (pc_en),
        .count(fetch_count)
    );
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  ((state != HALTED) && !pc_en),
        .count(stall_count)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of PC sequencing, redirects, data stalls, halt and counters
module tb_pc_sequencer;
    import cpu_types_pkg::*;
    logic CLK = 1'b0, nRST = 1'b0;
    logic ihit = 1'b0, dmem_req = 1'b0, dhit = 1'b0, halt = 1'b0;
    logic jr_req = 1'b0, j_req = 1'b0, br_req = 1'b0;
    logic pc_en, imemREN, stall, flush, halted;
    logic pc_en4, imemREN4, stall4, flush4, halted4;
    logic [1:0] pc_src, pc_src4;
    logic [31:0] fetch_count, stall_count;
    logic [3:0] fetch_count4, stall_count4;
    int n_chk = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    pc_sequencer u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit), .halt(halt),
        .jr_req(jr_req), .j_req(j_req), .br_req(br_req), .pc_en(pc_en), .pc_src(pc_src),
        .imemREN(imemREN), .stall(stall), .flush(flush), .halted(halted),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );

    pc_sequencer #(.CNT_W(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit), .halt(halt),
        .jr_req(jr_req), .j_req(j_req), .br_req(br_req), .pc_en(pc_en4), .pc_src(pc_src4),
        .imemREN(imemREN4), .stall(stall4), .flush(flush4), .halted(halted4),
        .fetch_count(fetch_count4), .stall_count(stall_count4)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 0; dmem_req = 0; dhit = 0; halt = 0; jr_req = 0; j_req = 0; br_req = 0;
    endtask

    task automatic do_reset();
        idle();
        nRST = 0;
        cyc();
        cyc();
        nRST = 1;
    endtask

    task automatic test_reset();
        nRST = 0; ihit = 1; j_req = 1;
        #1;
        n_chk++;
        if ({pc_en, flush, stall, halted, imemREN, pc_src} !== 7'b0000011) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0000011", {pc_en, flush, stall, halted, imemREN, pc_src});
        end
        cyc();
        n_chk++;
        if (fetch_count !== 32'd0 || stall_count !== 32'd0 || pc_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_held: fetch %0d stall %0d pc_en %b want 0 0 0", fetch_count, stall_count, pc_en);
        end
        idle();
        nRST = 1;
    endtask

    task automatic test_sequential();
        do_reset();
        ihit = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_chk++;
            if ({pc_en, pc_src, flush, stall} !== 5'b11100) begin
                n_fail++; $display("FAIL seq_fetch[%0d]: got %b want 11100", i, {pc_en, pc_src, flush, stall});
            end
            cyc();
        end
        ihit = 0;
        @(negedge CLK);
        n_chk++;
        if (fetch_count !== 32'd5 || stall_count !== 32'd0) begin
            n_fail++; $display("FAIL seq_counts: fetch %0d stall %0d want 5 0", fetch_count, stall_count);
        end
        n_chk++;
        if ({pc_en, stall, imemREN} !== 3'b001) begin
            n_fail++; $display("FAIL seq_noihit: got %b want 001", {pc_en, stall, imemREN});
        end
        cyc();
    endtask

    task automatic test_redirect_hit();
        do_reset();
        ihit = 1; j_req = 1; br_req = 1;
        @(negedge CLK);
        n_chk++;
        if ({pc_en, pc_src, flush} !== 4'b1011) begin
            n_fail++; $display("FAIL redir_j_over_br: got %b want 1011", {pc_en, pc_src, flush});
        end
        cyc();
        j_req = 0; br_req = 0;
        @(negedge CLK);
        n_chk++;
        if ({pc_en, pc_src, flush} !== 4'b1110 || u_dut.state !== RUN) begin
            n_fail++; $display("FAIL redir_one_cycle: got %b state %0d want 1110 state 0", {pc_en, pc_src, flush}, u_dut.state);
        end
        cyc();
        jr_req = 1; j_req = 1; br_req = 1;
        @(negedge CLK);
        n_chk++;
        if ({pc_en, pc_src, flush} !== 4'b1001) begin
            n_fail++; $display("FAIL redir_jr_first: got %b want 1001", {pc_en, pc_src, flush});
        end
        cyc();
        idle();
    endtask

    task automatic test_redirect_miss();
        do_reset();
        br_req = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) jr_req = 1;
            @(negedge CLK);
            n_chk++;
            if ({stall, pc_en, flush, imemREN} !== 4'b1001) begin
                n_fail++; $display("FAIL miss_stall[%0d]: got %b want 1001", i, {stall, pc_en, flush, imemREN});
            end
            cyc();
        end
        ihit = 1;
        @(negedge CLK);
        n_chk++;
        if ({pc_en, pc_src, flush} !== 4'b1101) begin
            n_fail++; $display("FAIL miss_apply_br: got %b want 1101", {pc_en, pc_src, flush});
        end
        cyc();
        idle();
        @(negedge CLK);
        n_chk++;
        if (stall_count !== 32'd3 || fetch_count !== 32'd1) begin
            n_fail++; $display("FAIL miss_counts: stall %0d fetch %0d want 3 1", stall_count, fetch_count);
        end
        n_chk++;
        if (u_dut.state !== RUN || stall !== 1'b0) begin
            n_fail++; $display("FAIL miss_back_run: state %0d stall %b want 0 0", u_dut.state, stall);
        end
        cyc();
    endtask

    task automatic test_dmem_wait();
        do_reset();
        dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            jr_req = (i == 1);
            @(negedge CLK);
            n_chk++;
            if ({imemREN, pc_en, stall} !== 3'b001) begin
                n_fail++; $display("FAIL dwait[%0d]: got %b want 001", i, {imemREN, pc_en, stall});
            end
            cyc();
        end
        jr_req = 0; dhit = 1;
        @(negedge CLK);
        n_chk++;
        if ({imemREN, pc_en, stall} !== 3'b001) begin
            n_fail++; $display("FAIL dwait_dhit: got %b want 001", {imemREN, pc_en, stall});
        end
        cyc();
        idle();
        @(negedge CLK);
        n_chk++;
        if (u_dut.state !== REDIRECT || {imemREN, stall, pc_en} !== 3'b110) begin
            n_fail++; $display("FAIL dwait_to_redirect: state %0d out %b want 2 110", u_dut.state, {imemREN, stall, pc_en});
        end
        cyc();
        ihit = 1;
        @(negedge CLK);
        n_chk++;
        if ({pc_en, pc_src, flush} !== 4'b1001) begin
            n_fail++; $display("FAIL dwait_apply_jr: got %b want 1001", {pc_en, pc_src, flush});
        end
        cyc();
        idle();
    endtask

    task automatic test_halt_dmem();
        do_reset();
        halt = 1; dmem_req = 1; ihit = 1;
        for (int i = 0; i < 3; i++) begin
            dhit = (i == 2);
            @(negedge CLK);
            n_chk++;
            if ({halted, pc_en, imemREN} !== 3'b000) begin
                n_fail++; $display("FAIL halt_wait[%0d]: got %b want 000", i, {halted, pc_en, imemREN});
            end
            cyc();
        end
        idle();
        ihit = 1; j_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_chk++;
            if ({halted, pc_en, imemREN, stall, flush} !== 5'b10000) begin
                n_fail++; $display("FAIL halted[%0d]: got %b want 10000", i, {halted, pc_en, imemREN, stall, flush});
            end
            cyc();
        end
        n_chk++;
        if (stall_count !== 32'd3 || fetch_count !== 32'd0) begin
            n_fail++; $display("FAIL halt_counts: stall %0d fetch %0d want 3 0", stall_count, fetch_count);
        end
        idle();
    endtask

    task automatic test_halt_direct();
        do_reset();
        ihit = 1;
        cyc();
        halt = 1;
        @(negedge CLK);
        n_chk++;
        if ({pc_en, halted} !== 2'b00) begin
            n_fail++; $display("FAIL halt_now: got %b want 00", {pc_en, halted});
        end
        cyc();
        halt = 0;
        @(negedge CLK);
        n_chk++;
        if ({halted, pc_en} !== 2'b10 || fetch_count !== 32'd1) begin
            n_fail++; $display("FAIL halt_now_after: got %b fetch %0d want 10 1", {halted, pc_en}, fetch_count);
        end
        cyc();
        idle();
    endtask

    task automatic test_reset_midstall();
        do_reset();
        br_req = 1;
        cyc();
        br_req = 0;
        #1;
        n_chk++;
        if (u_dut.state !== REDIRECT) begin
            n_fail++; $display("FAIL midstall_setup: state %0d want 2", u_dut.state);
        end
        nRST = 0;
        #1;
        n_chk++;
        if (u_dut.state !== RUN || {stall, imemREN, pc_src} !== 4'b0011) begin
            n_fail++; $display("FAIL midstall_reset: state %0d out %b want 0 0011", u_dut.state, {stall, imemREN, pc_src});
        end
        cyc();
        nRST = 1; ihit = 1;
        @(negedge CLK);
        n_chk++;
        if ({pc_en, pc_src, flush, stall} !== 5'b11100) begin
            n_fail++; $display("FAIL midstall_pending_gone: got %b want 11100", {pc_en, pc_src, flush, stall});
        end
        cyc();
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        ihit = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                n_chk++;
                if ({pc_en4, pc_src4, imemREN4, stall4, flush4, halted4} !== 7'b1111000) begin
                    n_fail++; $display("FAIL sat_outputs: got %b want 1111000", {pc_en4, pc_src4, imemREN4, stall4, flush4, halted4});
                end
            end
            cyc();
        end
        @(negedge CLK);
        n_chk++;
        if (fetch_count4 !== 4'd15 || stall_count4 !== 4'd0) begin
            n_fail++; $display("FAIL sat_fetch4: fetch %0d stall %0d want 15 0", fetch_count4, stall_count4);
        end
        n_chk++;
        if (fetch_count !== 32'd20) begin
            n_fail++; $display("FAIL sat_fetch32: got %0d want 20", fetch_count);
        end
        ihit = 0; halt = 1;
        cyc();
        halt = 0;
        @(negedge CLK);
        n_chk++;
        if ({halted, halted4} !== 2'b11) begin
            n_fail++; $display("FAIL sat_halted: got %b want 11", {halted, halted4});
        end
        nRST = 0;
        #1;
        n_chk++;
        if (u_dut4.state !== RUN || fetch_count4 !== 4'd0 || stall_count4 !== 4'd0 || halted4 !== 1'b0) begin
            n_fail++; $display("FAIL sat_reset: state %0d fetch %0d stall %0d halted %b want 0 0 0 0", u_dut4.state, fetch_count4, stall_count4, halted4);
        end
        cyc();
        nRST = 1; ihit = 1;
        @(negedge CLK);
        n_chk++;
        if ({pc_en4, halted4, pc_en, halted} !== 4'b1010) begin
            n_fail++; $display("FAIL sat_rerun: got %b want 1010", {pc_en4, halted4, pc_en, halted});
        end
        cyc();
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_hit();
        test_redirect_miss();
        test_dmem_wait();
        test_halt_dmem();
        test_halt_direct();
        test_reset_midstall();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
